// File: rtl/cpu_sequencer_pkg.sv
// Shared types and constants for the CPU instruction sequencer.
package cpu_sequencer_pkg;

    // Sequencer states; HALT is terminal until reset.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_REG   = 3'd2,
        S_EXEC  = 3'd3,
        S_CHECK = 3'd4,
        S_WAIT  = 3'd5,
        S_PCWB  = 3'd6,
        S_HALT  = 3'd7
    } seq_state_t;

    // Write-back channel indices.
    localparam int REG_WB  = 0;
    localparam int MEM_WB  = 1;
    localparam int FLAG_WB = 2;

    // Default bytes per instruction.
    localparam int DEF_PC_STEP = 2;

endpackage

// File: rtl/cpu_sequencer_wb_tracker.sv
// Write-back tracker: pending mask, one-cycle triggers and WAIT timeout.
module wb_tracker #(
    parameter int NWB        = 3,
    parameter int WB_TIMEOUT = 15
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic           active,
    input  logic [NWB-1:0] need,
    input  logic [NWB-1:0] done,
    output logic [NWB-1:0] wb_tr,
    output logic           all_done,
    output logic           timeout
);
    localparam int CW = $clog2(WB_TIMEOUT + 1);

    logic [NWB-1:0] pending;
    logic [CW-1:0]  cnt;
    logic [NWB-1:0] remaining;

    // Acks only matter for channels that are still pending.
    assign remaining = pending & ~done;
    assign all_done  = (remaining == '0);
    assign timeout   = active && !all_done && (cnt == CW'(WB_TIMEOUT));

    // Latch the mask at CHECK, retire acked channels and count WAIT cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
            wb_tr   <= '0;
            cnt     <= CW'(1);
        end else begin
            wb_tr <= load ? need : '0;
            if (load) begin
                pending <= need;
                cnt     <= CW'(1);
            end else if (active) begin
                pending <= timeout ? '0 : remaining;
                cnt     <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle instruction sequencer: FSM, PC register and retire bookkeeping.
module cpu_sequencer
    import cpu_sequencer_pkg::*;
#(
    parameter int WORD       = 16,
    parameter int NWB        = 3,
    parameter int PC_STEP    = DEF_PC_STEP,
    parameter int RESET_PC   = 0,
    parameter int WB_TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   halt_req,
    input  logic [NWB-1:0]         wb_need,
    input  logic [NWB-1:0]         wb_done,
    input  logic                   jump,
    input  logic                   rjump,
    input  logic [WORD-1:0]        jump_loc,
    input  logic signed [WORD-1:0] jump_inc,
    output logic [WORD-1:0]        pc,
    output logic                   fetch_tr,
    output logic                   reg_tr,
    output logic                   dne_tr,
    output logic [NWB-1:0]         wb_tr,
    output logic                   retire,
    output logic [WORD-1:0]        instr_count,
    output logic                   wb_error,
    output logic                   halted
);
    localparam logic [WORD-1:0] STEP = WORD'(PC_STEP);
    localparam logic [WORD-1:0] PC0  = WORD'(RESET_PC);

    seq_state_t state, next;
    logic       all_done, timeout;
    logic [WORD-1:0] pc_abs, pc_rel;

    wb_tracker #(.NWB(NWB), .WB_TIMEOUT(WB_TIMEOUT)) u_wb (
        .clk      (clk),
        .rst      (rst),
        .load     (state == S_CHECK),
        .active   (state == S_WAIT),
        .need     (wb_need),
        .done     (wb_done),
        .wb_tr    (wb_tr),
        .all_done (all_done),
        .timeout  (timeout)
    );

    // In PCWB pc already points past the executing instruction, hence -STEP.
    assign pc_abs = WORD'(jump_loc * STEP);
    assign pc_rel = pc + WORD'(jump_inc * STEP) - STEP;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= next;
    end

    // Next-state logic and Moore stage strobes.
    always_comb begin
        next     = state;
        fetch_tr = 1'b0;
        reg_tr   = 1'b0;
        dne_tr   = 1'b0;
        halted   = 1'b0;
        case (state)
            S_IDLE:  next = halt_req ? S_HALT : S_FETCH;
            S_FETCH: begin fetch_tr = 1'b1; next = S_REG; end
            S_REG:   begin reg_tr = 1'b1; next = S_EXEC; end
            S_EXEC:  begin dne_tr = 1'b1; next = S_CHECK; end
            S_CHECK: next = (wb_need == '0) ? S_PCWB : S_WAIT;
            S_WAIT:  if (all_done || timeout) next = S_PCWB;
            S_PCWB:  next = halt_req ? S_HALT : S_FETCH;
            S_HALT:  begin halted = 1'b1; next = S_HALT; end
            default: next = S_IDLE;
        endcase
    end

    // PC update, retire pulse, retired count and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= PC0;
            retire      <= 1'b0;
            instr_count <= '0;
            wb_error    <= 1'b0;
        end else begin
            retire <= (state == S_PCWB);
            if (state == S_REG) pc <= pc + STEP;
            if (state == S_PCWB) begin
                if (jump)       pc <= pc_abs;
                else if (rjump) pc <= pc_rel;
                instr_count <= instr_count + WORD'(1);
            end
            if (timeout) wb_error <= 1'b1;
        end
    end

endmodule
